// File: rtl/vx_gpr_rsp_collector.sv
// Operand collector: DEPTH in-order entries, NUM_SRCS operands each, filled out of order by NUM_PORTS write ports.
// Optional perf counters when GPR_RSP_COLLECTOR_PERF_EN is defined.
module vx_gpr_rsp_collector #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NUM_SRCS    = 3,
  parameter int DEPTH       = 4,
  parameter int NUM_PORTS   = 2,
  parameter int TAG_WIDTH   = 8,
  localparam int SLOT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SRC_W      = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1,
  localparam int OPW        = NUM_THREADS * XLEN
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [TAG_WIDTH-1:0]          req_tag,
  input  logic [NUM_SRCS-1:0]           req_mask,
  output logic [SLOT_W-1:0]             req_slot,
  input  logic [NUM_PORTS-1:0]          wr_valid,
  input  logic [NUM_PORTS*SLOT_W-1:0]   wr_slot,
  input  logic [NUM_PORTS*SRC_W-1:0]    wr_src,
  input  logic [NUM_PORTS*OPW-1:0]      wr_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  output logic [NUM_SRCS*OPW-1:0]       rsp_data,
`ifdef GPR_RSP_COLLECTOR_PERF_EN
  output logic [31:0]                   perf_stall_full,
  output logic [31:0]                   perf_wait_head,
`endif
  output logic                          wr_err
);

  localparam int CNT_W = SLOT_W + 1;

  logic [DEPTH-1:0]     alloc_q, alloc_d;
  logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
  logic [TAG_WIDTH-1:0] tag_d  [DEPTH];
  logic [NUM_SRCS-1:0]  need_q [DEPTH];
  logic [NUM_SRCS-1:0]  need_d [DEPTH];
  logic [NUM_SRCS-1:0]  have_q [DEPTH];
  logic [NUM_SRCS-1:0]  have_d [DEPTH];
  logic [OPW-1:0]       data_q [DEPTH][NUM_SRCS];
  logic [SLOT_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 wr_err_q, wr_err_d;

  logic [SLOT_W-1:0]    wslot [NUM_PORTS];
  logic [SRC_W-1:0]     wsrc  [NUM_PORTS];
  logic [NUM_PORTS-1:0] wr_ok;
  logic                 req_fire, rsp_fire;

  assign req_ready = (count_q != CNT_W'(DEPTH));
  assign rsp_valid = alloc_q[head_q] && ((need_q[head_q] & ~have_q[head_q]) == '0);
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign req_slot  = tail_q;
  assign rsp_tag   = tag_q[head_q];
  assign wr_err    = wr_err_q;

  always_comb begin
    rsp_data = '0;
    for (int unsigned s = 0; s < NUM_SRCS; s++) begin
      if (need_q[head_q][s]) rsp_data[s*OPW +: OPW] = data_q[head_q][s];
    end
  end

  always_comb begin
    alloc_d  = alloc_q;
    tag_d    = tag_q;
    need_d   = need_q;
    have_d   = have_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wr_err_d = 1'b0;
    wr_ok    = '0;

    // The slot being allocated this cycle still reads alloc=0, so such writes fall into the error path.
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      wslot[p] = wr_slot[p*SLOT_W +: SLOT_W];
      wsrc[p]  = wr_src[p*SRC_W +: SRC_W];
      if (wr_valid[p]) begin
        if (alloc_q[wslot[p]] && (32'(wsrc[p]) < 32'(NUM_SRCS))) begin
          wr_ok[p] = 1'b1;
          for (int unsigned s = 0; s < NUM_SRCS; s++) begin
            if (wsrc[p] == SRC_W'(s)) have_d[wslot[p]][s] = 1'b1;
          end
        end else begin
          wr_err_d = 1'b1;
        end
      end
    end

    if (rsp_fire) begin
      alloc_d[head_q] = 1'b0;
      head_d          = head_q + SLOT_W'(1);
    end

    if (req_fire) begin
      alloc_d[tail_q] = 1'b1;
      tag_d[tail_q]   = req_tag;
      need_d[tail_q]  = req_mask;
      have_d[tail_q]  = '0;
      tail_d          = tail_q + SLOT_W'(1);
    end

    case ({req_fire, rsp_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef GPR_RSP_COLLECTOR_PERF_EN
  logic [31:0] stall_full_q, stall_full_d, wait_head_q, wait_head_d;

  always_comb begin
    stall_full_d = stall_full_q;
    wait_head_d  = wait_head_q;
    if (req_valid && !req_ready && (stall_full_q != '1)) stall_full_d = stall_full_q + 32'd1;
    if (alloc_q[head_q] && !rsp_valid && (wait_head_q != '1)) wait_head_d = wait_head_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_full_q <= '0;
      wait_head_q  <= '0;
    end else begin
      stall_full_q <= stall_full_d;
      wait_head_q  <= wait_head_d;
    end
  end

  assign perf_stall_full = stall_full_q;
  assign perf_wait_head  = wait_head_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        need_q[i] <= '0;
        have_q[i] <= '0;
      end
    end else begin
      alloc_q  <= alloc_d;
      tag_q    <= tag_d;
      need_q   <= need_d;
      have_q   <= have_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Later ports are visited last, so on a slot/src collision the higher port's write lands.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned s = 0; s < NUM_SRCS; s++) begin
        if (wr_ok[p] && (wsrc[p] == SRC_W'(s))) data_q[wslot[p]][s] <= wr_data[p*OPW +: OPW];
      end
    end
  end

endmodule

// File: tb/tb_vx_gpr_rsp_collector.sv
// Bench for vx_gpr_rsp_collector: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against an occupancy/head based model of the collector.
module tb_vx_gpr_rsp_collector;

  localparam int NT   = 4;
  localparam int XL   = 32;
  localparam int NS   = 3;
  localparam int D    = 4;
  localparam int NP   = 2;
  localparam int TW   = 8;
  localparam int SW   = 2;
  localparam int SRCW = 2;
  localparam int OPW  = NT * XL;
  localparam int DW   = NS * OPW;

  localparam logic [OPW-1:0] A0  = {4{32'hA0A0_0001}};
  localparam logic [OPW-1:0] A1  = {4{32'hA1A1_0002}};
  localparam logic [OPW-1:0] A2  = {4{32'hA2A2_0003}};
  localparam logic [OPW-1:0] PAA = {16{8'hAA}};
  localparam logic [OPW-1:0] P55 = {16{8'h55}};

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid;
  logic              req_ready;
  logic [TW-1:0]     req_tag;
  logic [NS-1:0]     req_mask;
  logic [SW-1:0]     req_slot;
  logic [NP-1:0]     wr_valid;
  logic [NP*SW-1:0]  wr_slot;
  logic [NP*SRCW-1:0] wr_src;
  logic [NP*OPW-1:0] wr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [TW-1:0]     rsp_tag;
  logic [DW-1:0]     rsp_data;
  logic              wr_err;
`ifdef GPR_RSP_COLLECTOR_PERF_EN
  logic [31:0]       perf_stall_full, perf_wait_head;
`endif

  vx_gpr_rsp_collector #(
    .NUM_THREADS(NT), .XLEN(XL), .NUM_SRCS(NS), .DEPTH(D), .NUM_PORTS(NP), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_mask(req_mask),
    .req_slot(req_slot),
    .wr_valid(wr_valid), .wr_slot(wr_slot), .wr_src(wr_src), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
`ifdef GPR_RSP_COLLECTOR_PERF_EN
    .perf_stall_full(perf_stall_full), .perf_wait_head(perf_wait_head),
`endif
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  bit          cmp_en  = 1'b0;

  // Model: live entries are the cnt_m slots starting at head_m (mod D).
  int            cnt_m, head_m;
  bit            err_m;
  logic [TW-1:0] tag_m  [D];
  logic [NS-1:0] need_m [D];
  logic [NS-1:0] have_m [D];
  logic [OPW-1:0] data_m [D][NS];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit model_valid();
    return (cnt_m > 0) && ((need_m[head_m] & ~have_m[head_m]) == '0);
  endfunction

  function automatic logic [DW-1:0] model_data();
    logic [DW-1:0] r;
    r = '0;
    for (int s = 0; s < NS; s++)
      if (need_m[head_m][s]) r[s*OPW +: OPW] = data_m[head_m][s];
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    int  sz, tail, sl, sr;
    bit  rf, sf;
    if (!reset_n) begin
      cnt_m = 0; head_m = 0; err_m = 1'b0;
      for (int i = 0; i < D; i++) begin tag_m[i] = '0; need_m[i] = '0; have_m[i] = '0; end
    end else begin
      sz   = cnt_m;
      tail = (head_m + sz) % D;
      rf   = req_valid && (sz != D);
      sf   = model_valid() && rsp_ready;
      err_m = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (wr_valid[p]) begin
          sl = int'(wr_slot[p*SW +: SW]);
          sr = int'(wr_src[p*SRCW +: SRCW]);
          if ((((sl - head_m + D) % D) < sz) && (sr < NS)) begin
            data_m[sl][sr] = wr_data[p*OPW +: OPW];
            have_m[sl][sr] = 1'b1;
          end else begin
            err_m = 1'b1;
          end
        end
      end
      if (sf) begin head_m = (head_m + 1) % D; cnt_m--; end
      if (rf) begin
        tag_m[tail] = req_tag; need_m[tail] = req_mask; have_m[tail] = '0; cnt_m++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", DW'(req_ready), DW'(cnt_m != D));
      chk("req_slot",  DW'(req_slot),  DW'((head_m + cnt_m) % D));
      chk("rsp_valid", DW'(rsp_valid), DW'(model_valid()));
      chk("wr_err",    DW'(wr_err),    DW'(err_m));
      if (model_valid()) begin
        chk("rsp_tag",  DW'(rsp_tag), DW'(tag_m[head_m]));
        chk("rsp_data", rsp_data,     model_data());
      end
    end
  end

  task automatic idle();
    req_valid = 1'b0; req_tag = '0; req_mask = '0; rsp_ready = 1'b0;
    wr_valid = '0; wr_slot = '0; wr_src = '0; wr_data = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wp(input int p, input int slot, input int src, input logic [OPW-1:0] d);
    wr_valid[p] = 1'b1;
    wr_slot[p*SW +: SW]     = SW'(slot);
    wr_src[p*SRCW +: SRCW]  = SRCW'(src);
    wr_data[p*OPW +: OPW]   = d;
  endtask

  task automatic req(input logic [NS-1:0] m, input logic [TW-1:0] t);
    req_valid = 1'b1; req_mask = m; req_tag = t;
  endtask

  task automatic do_reset();
    idle();
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    chk("rst_ready", DW'(req_ready), DW'(1));
    chk("rst_valid", DW'(rsp_valid), DW'(0));
    chk("rst_slot",  DW'(req_slot),  DW'(0));
    chk("rst_err",   DW'(wr_err),    DW'(0));

    // Out-of-order operand arrival
    idle(); req(3'b111, 8'h11); step();
    idle(); wp(0, 0, 2, A2); step(); chk("s1_wait_a", DW'(rsp_valid), DW'(0));
    idle(); wp(0, 0, 0, A0); step(); chk("s1_wait_b", DW'(rsp_valid), DW'(0));
    idle(); wp(0, 0, 1, A1); step();
    chk("s1_valid", DW'(rsp_valid), DW'(1));
    chk("s1_tag",   DW'(rsp_tag),   DW'(8'h11));
    chk("s1_data",  rsp_data,       {A2, A1, A0});
    idle(); rsp_ready = 1'b1; step(); chk("s1_released", DW'(rsp_valid), DW'(0));

    // Fill, stall, in-order release with wrap
    do_reset();
    for (int t = 1; t <= 4; t++) begin idle(); req(3'b001, TW'(t)); step(); end
    chk("s2_full", DW'(req_ready), DW'(0));
    idle(); req(3'b001, 8'd5); step();
    chk("s2_stall_ready", DW'(req_ready), DW'(0));
    chk("s2_stall_slot",  DW'(req_slot),  DW'(0));
    idle(); req(3'b001, 8'd5); wp(0, 1, 0, A1); step();
    chk("s3_head_blocks", DW'(rsp_valid), DW'(0));
    idle(); req(3'b001, 8'd5); wp(0, 0, 0, A0); step();
    chk("s3_head_valid", DW'(rsp_valid), DW'(1));
    chk("s3_first_tag",  DW'(rsp_tag),   DW'(1));
    idle(); req(3'b001, 8'd5); rsp_ready = 1'b1; step();
    chk("s2_ready_again", DW'(req_ready), DW'(1));
    chk("s2_tail_wrap",   DW'(req_slot),  DW'(0));
    chk("s3_second_tag",  DW'(rsp_tag),   DW'(2));
    idle(); req(3'b001, 8'd5); step();
    chk("s2_refill_full", DW'(req_ready), DW'(0));

    // Port collision and error writes
    do_reset();
    idle(); req(3'b001, 8'h22); step();
    idle(); wp(0, 0, 0, PAA); wp(1, 0, 0, P55); step();
    chk("s4_valid",     DW'(rsp_valid), DW'(1));
    chk("s4_port_prio", rsp_data,       DW'(P55));
    idle(); wp(0, 3, 0, PAA); step();
    chk("s5_free_err",  DW'(wr_err),    DW'(1));
    chk("s5_free_data", rsp_data,       DW'(P55));
    idle(); step();
    chk("s5_err_pulse", DW'(wr_err),    DW'(0));
    idle(); wp(0, 0, 3, PAA); step();
    chk("s5_src_err",   DW'(wr_err),    DW'(1));
    chk("s5_src_data",  rsp_data,       DW'(P55));
    chk("s5_src_slot",  DW'(req_slot),  DW'(1));
    idle(); req(3'b001, 8'h33); wp(1, 1, 0, PAA); step();
    chk("s5_alloc_err", DW'(wr_err),    DW'(1));

    // Empty-mask entry and asynchronous reset while holding
    do_reset();
    idle(); req(3'b000, 8'h7F); step();
    chk("s6_valid", DW'(rsp_valid), DW'(1));
    chk("s6_tag",   DW'(rsp_tag),   DW'(8'h7F));
    chk("s6_data",  rsp_data,       DW'(0));
    idle(); step();
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_valid", DW'(rsp_valid), DW'(0));
    chk("s6_rst_ready", DW'(req_ready), DW'(1));
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      if ($urandom_range(0, 1) == 1) req(NS'($urandom), TW'($urandom));
      rsp_ready = ($urandom_range(0, 9) < 6);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1)
          wp(p, $urandom_range(0, D - 1),
             ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, NS - 1),
             {$urandom, $urandom, $urandom, $urandom});
      end
      step();
    end

    idle();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
